// File: rtl/shift_burst_pkg.sv
// shift_burst_pkg: mode/state encodings and counter-width helper for shift_burst_unit
package shift_burst_pkg;
  typedef enum logic [1:0] {MODE_LOGIC = 2'b00, MODE_ROT = 2'b01, MODE_ARITH = 2'b10} mode_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_t;
  function automatic int cnt_w(input int max_steps);
    return $clog2(max_steps + 1);
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one STEP-bit shift of a word; arithmetic mode compiled in by SHIFT_BURST_ARITH_EN
module shift_step import shift_burst_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STEP = 4
) (
  input  logic [WIDTH-1:0] word,
  input  logic [STEP-1:0]  fill,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] word_nx
);
  logic [STEP-1:0] ins;
  // Pick the bits entering the vacated end, then shift them in
  always_comb begin
`ifdef SHIFT_BURST_ARITH_EN
    ins = mode == MODE_ROT ? (dir ? word[STEP-1:0] : word[WIDTH-1 -: STEP]) :
          mode == MODE_ARITH ? (dir ? {STEP{word[WIDTH-1]}} : '0) : fill;
`else
    ins = mode == MODE_ROT ? (dir ? word[STEP-1:0] : word[WIDTH-1 -: STEP]) : fill;
`endif
    word_nx = dir ? WIDTH'({ins, word} >> STEP) : WIDTH'({word, ins});
  end
endmodule

// File: rtl/shift_burst_unit.sv
// shift_burst_unit: valid/ready burst shifter; SHIFT_BURST_ARITH_EN enables arithmetic mode 10
module shift_burst_unit import shift_burst_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  parameter int MAX_STEPS = 15,
  parameter int CNT_W = cnt_w(MAX_STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [STEP-1:0]  in_fill,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  state_t state, state_nx;
  logic [WIDTH-1:0] word, word_nx;
  logic [STEP-1:0] fill;
  logic dir;
  logic [1:0] mode;
  logic [CNT_W-1:0] rem, cnt_sat;
  logic accept;
  assign accept = in_valid && in_ready;
  if ((2 ** CNT_W) - 1 > MAX_STEPS) begin : g_sat
    assign cnt_sat = int'(in_count) > MAX_STEPS ? CNT_W'(MAX_STEPS) : in_count;
  end else begin : g_nosat
    assign cnt_sat = in_count;
  end
  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .word(word), .fill(fill), .dir(dir), .mode(mode), .word_nx(word_nx)
  );
  // State register
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : state_nx;
  // Next state: accept in IDLE, count down in SHIFT, wait for consumer in DONE
  always_comb
    state_nx = state == ST_IDLE ? (accept ? ST_SHIFT : ST_IDLE) :
               state == ST_SHIFT ? (rem == '0 ? ST_DONE : ST_SHIFT) :
               (out_ready ? ST_IDLE : ST_DONE);
  // Handshake and status outputs, forced low while reset is asserted
  always_comb begin
    in_ready = !rst && state == ST_IDLE;
    out_valid = !rst && state == ST_DONE;
    busy = !rst && (state == ST_SHIFT || state == ST_DONE);
  end
  // Operand capture, step countdown and result register
  always_ff @(posedge clk)
    if (rst) begin
      word <= '0;
      fill <= '0;
      dir <= 1'b0;
      mode <= '0;
      rem <= '0;
      out_data <= '0;
    end else if (accept) begin
      word <= in_data;
      fill <= in_fill;
      dir <= in_dir;
      mode <= in_mode;
      rem <= cnt_sat;
    end else if (state == ST_SHIFT) begin
      if (rem == '0) out_data <= word;
      else begin
        word <= word_nx;
        rem <= rem - CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_shift_burst_unit.sv
// tb_shift_burst_unit: directed self-checking bench for shift_burst_unit
module tb_shift_burst_unit;
  logic clk = 0, rst = 1, in_valid = 0, in_dir = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [31:0] in_data = 0, out_data;
  logic [3:0] in_fill = 0, in_count = 0;
  logic [1:0] in_mode = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  shift_burst_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fill(in_fill), .in_count(in_count), .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [31:0] d, input logic [3:0] f, input logic [3:0] c,
                       input logic dr, input logic [1:0] m);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("ready", in_ready, 1);
    in_data = d; in_fill = f; in_count = c; in_dir = dr; in_mode = m; in_valid = 1;
    tick();
    in_valid = 0;
    in_data = 32'hA5A5A5A5; in_fill = 4'h3; in_count = 4'h7; in_dir = ~dr; in_mode = 2'b01;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] d, input logic [3:0] f,
                     input logic [3:0] c, input logic dr, input logic [1:0] m,
                     input logic [31:0] exp, input int lat);
    int cyc;
    start(d, f, c, dr, m);
    wait_valid(cyc);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_data"}, out_data, exp);
    tick();
    chk({tag, "_idle"}, in_ready, 1);
  endtask
  initial begin
    int cyc;
    logic [31:0] held;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    rst = 0;
    #1;
    chk("rst_rdy_after", in_ready, 1);
    run("ll2", 32'h12345678, 4'hF, 4'd2, 0, 2'b00, 32'h345678FF, 3);
    run("rr1", 32'h12345678, 4'h0, 4'd1, 1, 2'b01, 32'h81234567, 2);
    run("c0", 32'hDEADBEEF, 4'h9, 4'd0, 0, 2'b01, 32'hDEADBEEF, 1);
    run("rl15", 32'h12345678, 4'h0, 4'd15, 0, 2'b01, 32'h81234567, 16);
    run("lr3", 32'h12345678, 4'hA, 4'd3, 1, 2'b00, 32'hAAA12345, 4);
    run("rl1", 32'h12345678, 4'h0, 4'd1, 0, 2'b01, 32'h23456781, 2);
    run("m11", 32'h12345678, 4'h0, 4'd2, 1, 2'b11, 32'h00123456, 3);
    run("ll1", 32'hFFFFFFFF, 4'h5, 4'd1, 0, 2'b00, 32'hFFFFFFF5, 2);
`ifdef SHIFT_BURST_ARITH_EN
    run("ar1", 32'h80000000, 4'h0, 4'd1, 1, 2'b10, 32'hF8000000, 2);
    run("al1", 32'h80000001, 4'hF, 4'd1, 0, 2'b10, 32'h00000010, 2);
`else
    run("ar1", 32'h80000000, 4'h0, 4'd1, 1, 2'b10, 32'h08000000, 2);
    run("al1", 32'h80000001, 4'hF, 4'd1, 0, 2'b10, 32'h0000001F, 2);
`endif
    out_ready = 0;
    start(32'h12345678, 4'h0, 4'd1, 1, 2'b01);
    wait_valid(cyc);
    chk("bp_lat", cyc, 2);
    held = out_data;
    chk("bp_data0", held, 32'h81234567);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'h81234567);
      chk("bp_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_idle", in_ready, 1);
    chk("bp_drop", out_valid, 0);
    chk("bp_nbusy", busy, 0);
    start(32'h12345678, 4'h0, 4'd10, 0, 2'b00);
    tick(); tick(); tick();
    chk("ab_busy_pre", busy, 1);
    rst = 1;
    tick();
    chk("ab_valid", out_valid, 0);
    chk("ab_data", out_data, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready_rst", in_ready, 0);
    rst = 0;
    #1;
    chk("ab_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) tick();
    chk("ab_nopartial", out_valid, 0);
    chk("ab_data_hold", out_data, 0);
    run("post", 32'h0000000F, 4'h0, 4'd1, 0, 2'b00, 32'h000000F0, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
